// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the PC register and decode.
// Issues one instruction-memory read at a time for the current PC, buffers
// returned words with their addresses in an in-order FIFO, and presents the
// head entry to decode through a valid/deq handshake.
// Optional feature macro: FETCH_BYPASS_EN (forwards a response straight to
// decode when the FIFO is empty).
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] iaddr,
  input  logic          flush,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [AW-1:0] imem_rdata,
  input  logic          deq,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic          pc_adv,
  output logic          inst_valid,
  output logic [AW-1:0] inst,
  output logic [AW-1:0] inst_addr,
  output logic          full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  // One buffered instruction: fetch address plus the returned word.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
  } entry_t;

  state_t        state;
  state_t        state_nxt;
  logic          load_addr;

  entry_t        mem [DEPTH];
  entry_t        head_c;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          fifo_empty_c;
  logic          rsp_ok_c;
  logic          push_c;
  logic          pop_c;

  assign fifo_empty_c = (count == '0);
  assign head_c       = mem[rd_ptr];

  // A response is usable only when it answers a live (non-flushed) read.
  assign rsp_ok_c = (state == WAIT) && imem_rvalid && !flush;

`ifdef FETCH_BYPASS_EN
  logic byp_c;
  // Forward straight to decode when nothing older is queued.
  assign byp_c  = rsp_ok_c && fifo_empty_c;
  assign push_c = rsp_ok_c && !(byp_c && deq);
`else
  assign push_c = rsp_ok_c;
`endif

  // Pops only a real entry; flush takes precedence over a same-cycle deq.
  assign pop_c = deq && !fifo_empty_c && !flush;

  // Occupancy after this edge, used both by the FIFO and the WAIT exit.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(push_c) - CW'(pop_c);
    end
  end

  // The outstanding read reserves a slot, so WAIT counts toward full.
  assign full = ((count + CW'(state == WAIT)) == CW'(DEPTH));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and request/advance outputs.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    pc_adv    = 1'b0;
    load_addr = 1'b0;
    case (state)
      IDLE: begin
        if (!full && !flush) begin
          state_nxt = REQ;
          load_addr = 1'b1;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (flush) begin
          // A granted read must still be drained; an ungranted one is dropped.
          state_nxt = imem_gnt ? DROP : IDLE;
        end else if (imem_gnt) begin
          state_nxt = WAIT;
          pc_adv    = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_nxt = IDLE;
          end else if (count_nxt != CW'(DEPTH)) begin
            state_nxt = REQ;
            load_addr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request address is captured only on entry to REQ and held until grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= '0;
    end else if (load_addr) begin
      imem_addr <= iaddr;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
    end
  end

  // FIFO storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{addr: imem_addr, data: imem_rdata};
    end
  end

  // Head presentation to decode; fields read as zero while empty.
  always_comb begin
    inst_valid = !fifo_empty_c;
    inst       = '0;
    inst_addr  = '0;
    if (!fifo_empty_c) begin
      inst      = head_c.data;
      inst_addr = head_c.addr;
    end
`ifdef FETCH_BYPASS_EN
    else if (byp_c) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_addr  = imem_addr;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario-driven self-checking bench for fetch_queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected {addr,data} pairs are queued as responses are
// driven and compared when decode consumes them.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic        flush;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        deq;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        pc_adv;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        full;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .iaddr       (iaddr),
    .flush       (flush),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .deq         (deq),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_adv      (pc_adv),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_addr   (inst_addr),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Move to just after the next rising edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reset with all inputs idle; returns with rst released and state IDLE.
  task automatic do_reset(input logic [31:0] pc);
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; deq = 1'b0; iaddr = pc;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'hFFFF_FFFF; deq = 1'b0; iaddr = 32'h100;
    #2;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", imem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", inst_valid); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
    do_reset(32'h100);
    adv(); imem_gnt = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rstw_req got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rstw_addr got=%h want=100", imem_addr); end
    total++; if (pc_adv !== 1'b1) begin bad++; $display("FAIL rstw_pcadv got=%0b want=1", pc_adv); end
    adv(); imem_gnt = 1'b0; iaddr = 32'h104;
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstw_wait_req got=%0b want=0", imem_req); end
    // Reset while the read is outstanding.
    #1; rst = 1'b1; iaddr = 32'h200;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%0b want=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%h want=0", imem_addr); end
    total++; if (pc_adv !== 1'b0) begin bad++; $display("FAIL midrst_pcadv got=%0b want=0", pc_adv); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", inst_valid); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL midrst_inst got=%h want=0", inst); end
    total++; if (inst_addr !== 32'h0) begin bad++; $display("FAIL midrst_iaddr got=%h want=0", inst_addr); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL midrst_full got=%0b want=0", full); end
    @(posedge clk); #1; rst = 1'b0;
    adv();
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL postrst_req got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL postrst_addr got=%h want=200", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    logic [31:0] pc;
    logic [63:0] exp;
    int pulses;
    words[0] = 32'hE3A01001; words[1] = 32'hE2811001; words[2] = 32'hEAFFFFFE;
    pc = 32'h0; pulses = 0;
    do_reset(pc);
    deq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adv(); imem_gnt = 1'b1; imem_rvalid = 1'b0;
      @(negedge clk);
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req[%0d] got=%0b want=1", i, imem_req); end
      total++; if (imem_addr !== pc) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, imem_addr, pc); end
      if (pc_adv === 1'b1) pulses++;
      if (inst_valid === 1'b1 && deq) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stream_extra got=%h want=none", inst); end
        else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL stream_data got=%h want=%h", {inst_addr, inst}, exp); end end
      end
      adv(); imem_gnt = 1'b0; sb.push_back({pc, words[i]});
      pc = pc + 32'd4; iaddr = pc; imem_rvalid = 1'b1; imem_rdata = words[i];
      @(negedge clk);
      if (pc_adv === 1'b1) pulses++;
      if (inst_valid === 1'b1 && deq) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stream_extra got=%h want=none", inst); end
        else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL stream_data got=%h want=%h", {inst_addr, inst}, exp); end end
      end
    end
    adv(); imem_rvalid = 1'b0;
    @(negedge clk);
    if (inst_valid === 1'b1 && deq) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL stream_extra got=%h want=none", inst); end
      else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL stream_data got=%h want=%h", {inst_addr, inst}, exp); end end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL stream_pulses got=%0d want=3", pulses); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_left got=%0d want=0", sb.size()); end
    deq = 1'b0;
    sb.delete();
  endtask

  task automatic test_full();
    logic [31:0] pc;
    logic [63:0] exp;
    logic found;
    pc = 32'h80; found = 1'b0;
    do_reset(pc);
    for (int i = 0; i < 4; i++) begin
      adv(); imem_gnt = 1'b1; imem_rvalid = 1'b0;
      @(negedge clk);
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL full_req[%0d] got=%0b want=1", i, imem_req); end
      total++; if (imem_addr !== pc) begin bad++; $display("FAIL full_addr[%0d] got=%h want=%h", i, imem_addr, pc); end
      adv(); imem_gnt = 1'b0; sb.push_back({pc, 32'hA000_0000 + 32'(i)});
      pc = pc + 32'd4; iaddr = pc; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      total++; if (full !== (i == 3)) begin bad++; $display("FAIL full_wait[%0d] got=%0b want=%0b", i, full, (i == 3)); end
    end
    adv(); imem_rvalid = 1'b0;
    @(negedge clk);
    exp = sb[0];
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0b want=1", full); end
    total++; if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL full_head got=%h want=%h", {inst_addr, inst}, exp); end
    for (int k = 0; k < 3; k++) begin
      adv();
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_noreq[%0d] got=%0b want=0", k, imem_req); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL full_hold[%0d] got=%0b want=1", k, full); end
    end
    adv(); deq = 1'b1;
    @(negedge clk);
    if (inst_valid === 1'b1 && deq) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL full_extra got=%h want=none", inst); end
      else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL full_data got=%h want=%h", {inst_addr, inst}, exp); end end
    end
    for (int k = 0; k < 2; k++) begin
      if (!found) begin
        adv(); deq = 1'b0;
        @(negedge clk);
        if (k == 0) begin
          total++; if (full !== 1'b0) begin bad++; $display("FAIL full_drop got=%0b want=0", full); end
        end
        if (imem_req === 1'b1) found = 1'b1;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL full_rereq_timeout got=%0b want=1", found); end
    total++; if (imem_addr !== pc) begin bad++; $display("FAIL full_readdr got=%h want=%h", imem_addr, pc); end
    for (int j = 0; j < 3; j++) begin
      adv(); deq = 1'b1;
      @(negedge clk);
      if (inst_valid === 1'b1 && deq) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL full_extra got=%h want=none", inst); end
        else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL full_data got=%h want=%h", {inst_addr, inst}, exp); end end
      end
    end
    adv(); deq = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b want=0", inst_valid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL full_left got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_flush_wait();
    logic [63:0] exp;
    do_reset(32'h20);
    adv(); imem_gnt = 1'b1;
    @(negedge clk);
    adv(); imem_gnt = 1'b0; flush = 1'b1; iaddr = 32'h24;
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fw_req got=%0b want=0", imem_req); end
    adv(); flush = 1'b0; iaddr = 32'h40;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fw_drop_valid[%0d] got=%0b want=0", k, inst_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fw_drop_req[%0d] got=%0b want=0", k, imem_req); end
      adv();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; deq = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fw_dead_valid got=%0b want=0", inst_valid); end
    adv(); imem_rvalid = 1'b0; deq = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fw_after_valid got=%0b want=0", inst_valid); end
    adv(); imem_gnt = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fw_newreq got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL fw_newaddr got=%h want=40", imem_addr); end
    adv(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE1A00000; iaddr = 32'h44; deq = 1'b1;
    sb.push_back({32'h40, 32'hE1A00000});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (inst_valid === 1'b1 && deq) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL fw_extra got=%h want=none", inst); end
        else begin exp = sb.pop_front(); if ({inst_addr, inst} !== exp) begin bad++; $display("FAIL fw_data got=%h want=%h", {inst_addr, inst}, exp); end end
      end
      adv(); imem_rvalid = 1'b0;
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL fw_left got=%0d want=0", sb.size()); end
    deq = 1'b0;
    sb.delete();
  endtask

  task automatic test_flush_gnt();
    do_reset(32'h60);
    adv(); imem_gnt = 1'b1; flush = 1'b1;
    @(negedge clk);
    total++; if (pc_adv !== 1'b0) begin bad++; $display("FAIL fg_pcadv got=%0b want=0", pc_adv); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fg_req got=%0b want=1", imem_req); end
    adv(); imem_gnt = 1'b0; flush = 1'b0; iaddr = 32'h70;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fg_drop_req[%0d] got=%0b want=0", k, imem_req); end
      adv();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0; deq = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fg_rsp_valid got=%0b want=0", inst_valid); end
    adv(); imem_rvalid = 1'b0; deq = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fg_after_valid got=%0b want=0", inst_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fg_idle_req got=%0b want=0", imem_req); end
    adv();
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fg_newreq got=%0b want=1", imem_req); end
    total++; if (imem_addr !== 32'h70) begin bad++; $display("FAIL fg_newaddr got=%h want=70", imem_addr); end
  endtask

  task automatic test_flush_fifo();
    logic [31:0] pc;
    pc = 32'h500;
    do_reset(pc);
    for (int i = 0; i < 2; i++) begin
      adv(); imem_gnt = 1'b1; imem_rvalid = 1'b0;
      @(negedge clk);
      adv(); imem_gnt = 1'b0; pc = pc + 32'd4; iaddr = pc; imem_rvalid = 1'b1; imem_rdata = 32'(i);
      @(negedge clk);
    end
    adv(); imem_rvalid = 1'b0; flush = 1'b1; deq = 1'b1;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL ff_pre_valid got=%0b want=1", inst_valid); end
    total++; if (inst_addr !== 32'h500) begin bad++; $display("FAIL ff_pre_addr got=%h want=500", inst_addr); end
    adv(); flush = 1'b0; deq = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ff_post_valid got=%0b want=0", inst_valid); end
  endtask

  task automatic test_bypass();
    do_reset(32'h300);
    adv(); imem_gnt = 1'b1;
    @(negedge clk);
    adv(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h12345678; iaddr = 32'h304; deq = 1'b1;
    @(negedge clk);
`ifdef FETCH_BYPASS_EN
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%0b want=1", inst_valid); end
    total++; if (inst !== 32'h12345678) begin bad++; $display("FAIL byp_inst got=%h want=12345678", inst); end
    total++; if (inst_addr !== 32'h300) begin bad++; $display("FAIL byp_addr got=%h want=300", inst_addr); end
    adv(); imem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL byp_consumed got=%0b want=0", inst_valid); end
`else
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL nobyp_same got=%0b want=0", inst_valid); end
    adv(); imem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL nobyp_next got=%0b want=1", inst_valid); end
    total++; if (inst !== 32'h12345678) begin bad++; $display("FAIL nobyp_inst got=%h want=12345678", inst); end
    total++; if (inst_addr !== 32'h300) begin bad++; $display("FAIL nobyp_addr got=%h want=300", inst_addr); end
    adv(); deq = 1'b0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL nobyp_popped got=%0b want=0", inst_valid); end
`endif
    deq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_flush_wait();
    test_flush_gnt();
    test_flush_fifo();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
